// File: rtl/pts_tx_arbiter.sv
// Round-robin two-channel transmit scheduler that owns the load/shift controls
// of a shared parallel-to-serial shift register and paces one shift per bit period.
module pts_tx_arbiter #(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    input  logic [NUM_BITS-1:0] req_data0,
    input  logic [NUM_BITS-1:0] req_data1,
    output logic [1:0]          req_ready,
    output logic                load_enable,
    output logic                shift_enable,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic                tx_active,
    output logic                tx_done,
    output logic                grant_id
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(NUM_BITS);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state, state_d;
    logic          prio, prio_d;
    logic          grant_q, grant_d;
    logic [CW-1:0] clk_cnt, clk_cnt_d;
    logic [BW-1:0] bit_cnt, bit_cnt_d;
    logic          sel;
    logic          bit_tick;
    logic          last_bit;

    assign bit_tick = (clk_cnt == CLK_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prio    <= 1'b0;
            grant_q <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_d;
            prio    <= prio_d;
            grant_q <= grant_d;
            clk_cnt <= clk_cnt_d;
            bit_cnt <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d      = state;
        prio_d       = prio;
        grant_d      = grant_q;
        clk_cnt_d    = clk_cnt;
        bit_cnt_d    = bit_cnt;
        sel          = 1'b0;
        req_ready    = 2'b00;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        parallel_out = '1;
        tx_active    = 1'b0;
        tx_done      = 1'b0;
        grant_id     = grant_q;

        // Reset loads all ones so the serializer flushes to the idle-high level.
        if (rst) begin
            load_enable = 1'b1;
            grant_id    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        sel          = (&req_valid) ? prio : req_valid[1];
                        req_ready    = sel ? 2'b10 : 2'b01;
                        load_enable  = 1'b1;
                        parallel_out = sel ? req_data1 : req_data0;
                        grant_id     = sel;
                        grant_d      = sel;
                        prio_d       = ~sel;
                        clk_cnt_d    = '0;
                        bit_cnt_d    = '0;
                        state_d      = SEND;
                    end
                end
                SEND: begin
                    tx_active = 1'b1;
                    clk_cnt_d = clk_cnt + 1'b1;
                    if (bit_tick) begin
                        shift_enable = 1'b1;
                        clk_cnt_d    = '0;
                        bit_cnt_d    = bit_cnt + 1'b1;
                        // The final shift pulls the fill ones in, leaving the line high.
                        if (last_bit) begin
                            tx_done   = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pts_tx_arbiter.sv
// Table-driven bench for pts_tx_arbiter: per-cycle vectors for the default
// 8-bit/4-clock instance plus a hand sequence for a 4-bit/1-clock instance.
module tb_pts_tx_arbiter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] req_valid;
    logic [7:0] req_data0, req_data1;
    logic [1:0] req_ready;
    logic       load_enable, shift_enable, tx_active, tx_done, grant_id;
    logic [7:0] parallel_out;

    logic       e_rst;
    logic [1:0] e_valid;
    logic [3:0] e_d0, e_d1;
    logic [1:0] e_ready;
    logic       e_load, e_shift, e_active, e_done, e_gid;
    logic [3:0] e_pout;

    pts_tx_arbiter #(.NUM_BITS(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_ready(req_ready), .load_enable(load_enable),
        .shift_enable(shift_enable), .parallel_out(parallel_out),
        .tx_active(tx_active), .tx_done(tx_done), .grant_id(grant_id)
    );

    pts_tx_arbiter #(.NUM_BITS(4), .CLKS_PER_BIT(1)) dut_e (
        .clk(clk), .rst(e_rst), .req_valid(e_valid),
        .req_data0(e_d0), .req_data1(e_d1),
        .req_ready(e_ready), .load_enable(e_load),
        .shift_enable(e_shift), .parallel_out(e_pout),
        .tx_active(e_active), .tx_done(e_done), .grant_id(e_gid)
    );

    // exp = {req_ready[1:0], load, shift, active, done, grant_id, parallel_out[7:0]}
    typedef struct {
        string       tag;
        logic        rst;
        logic [1:0]  vld;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [14:0] mk(input logic [1:0] rdy, input logic ld, input logic sh,
                                       input logic act, input logic done, input logic gid,
                                       input logic [7:0] po);
        return {rdy, ld, sh, act, done, gid, po};
    endfunction

    task automatic add(input string tag, input logic r, input logic [1:0] v,
                       input logic [7:0] a, input logic [7:0] b, input logic [14:0] e);
        vec_t x;
        x.tag = tag; x.rst = r; x.vld = v; x.d0 = a; x.d1 = b; x.exp = e;
        vecs.push_back(x);
    endtask

    task automatic add_reset(input string tag, input int n, input logic [1:0] v,
                             input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < n; i++) add(tag, 1'b1, v, a, b, mk(2'b00, 1, 0, 0, 0, 0, 8'hFF));
    endtask

    task automatic add_idle(input string tag, input int n, input logic gid);
        for (int i = 0; i < n; i++) add(tag, 1'b0, 2'b00, 8'h00, 8'h00, mk(2'b00, 0, 0, 0, 0, gid, 8'hFF));
    endtask

    // Grant cycle followed by 32 SEND cycles (8 bits x 4 clocks).
    task automatic add_frame(input string tag, input logic [1:0] v_grant, input logic [1:0] v_rest,
                             input logic [7:0] a, input logic [7:0] b, input logic sel);
        add(tag, 1'b0, v_grant, a, b,
            mk(sel ? 2'b10 : 2'b01, 1, 0, 0, 0, sel, sel ? b : a));
        for (int p = 1; p <= 32; p++)
            add(tag, 1'b0, v_rest, a, b,
                mk(2'b00, 0, (p % 4) == 0, 1, p == 32, sel, 8'hFF));
    endtask

    logic [14:0] got;
    logic [10:0] e_got;
    logic [10:0] e_exp [7];

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00;
        e_rst = 1'b1; e_valid = 2'b00; e_d0 = 4'h0; e_d1 = 4'h0;

        add_reset("reset", 2, 2'b00, 8'h00, 8'h00);
        add_idle("idle_after_reset", 20, 1'b0);
        add_frame("single_A5", 2'b01, 2'b00, 8'hA5, 8'h00, 1'b0);
        add_idle("idle_after_single", 1, 1'b0);

        add_reset("reset_pre_contention", 1, 2'b00, 8'h00, 8'h00);
        add_frame("contention_ch0", 2'b11, 2'b10, 8'h3C, 8'hC3, 1'b0);
        add_frame("contention_ch1", 2'b10, 2'b00, 8'h3C, 8'hC3, 1'b1);
        add_idle("idle_after_contention", 1, 1'b1);

        add_reset("reset_pre_fair", 1, 2'b00, 8'h00, 8'h00);
        for (int f = 0; f < 4; f++)
            add_frame("fairness", 2'b11, 2'b11, 8'h3C, 8'hC3, f[0]);

        add_reset("reset_pre_midframe", 1, 2'b00, 8'h00, 8'h00);
        add("midframe_grant", 1'b0, 2'b10, 8'h00, 8'h5A, mk(2'b10, 1, 0, 0, 0, 1, 8'h5A));
        for (int p = 1; p <= 9; p++)
            add("midframe_send", 1'b0, 2'b10, 8'h00, 8'h5A,
                mk(2'b00, 0, (p % 4) == 0, 1, 0, 1, 8'hFF));
        add_reset("midframe_reset", 2, 2'b10, 8'h00, 8'h5A);
        add_frame("regrant_ch1", 2'b10, 2'b00, 8'h00, 8'h5A, 1'b1);
        add_idle("idle_end", 2, 1'b1);

        // Edge instance expectations: {rdy, ld, sh, act, done, gid, pout[3:0]}
        e_exp[0] = {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF};
        e_exp[1] = {2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9};
        e_exp[2] = {2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF};
        e_exp[3] = {2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF};
        e_exp[4] = {2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF};
        e_exp[5] = {2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF};
        e_exp[6] = {2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6};

        foreach (vecs[i]) begin
            rst = vecs[i].rst; req_valid = vecs[i].vld;
            req_data0 = vecs[i].d0; req_data1 = vecs[i].d1;
            @(negedge clk);
            got = {req_ready, load_enable, shift_enable, tx_active, tx_done, grant_id, parallel_out};
            n_vec++;
            if (got !== vecs[i].exp) begin
                n_bad++;
                $display("FAIL vec %0d %s: got %h want %h", i, vecs[i].tag, got, vecs[i].exp);
            end
            @(posedge clk); #1;
        end

        // Edge instance: reset cycle, grant at 0, shifts 1..4, done at 4, regrant at 5.
        rst = 1'b1; req_valid = 2'b00;
        for (int c = 0; c < 7; c++) begin
            e_rst   = (c == 0);
            e_valid = (c == 1) ? 2'b01 : (c == 6) ? 2'b10 : 2'b00;
            e_d0    = 4'h9;
            e_d1    = 4'h6;
            @(negedge clk);
            e_got = {e_ready, e_load, e_shift, e_active, e_done, e_gid, e_pout};
            n_vec++;
            if (e_got !== e_exp[c]) begin
                n_bad++;
                $display("FAIL edge_c%0d: got %h want %h", c, e_got, e_exp[c]);
            end
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
